suprloco_sram_dma: RTL and testbench

//  Initiator-side block-transfer engine for the single-port synchronous SRAMs (work RAM, VRAM, line RAM).

---
 rtl/suprloco_dma_pkg.sv | 20 ++
 rtl/suprloco_sram_dma.sv | 139 +++++++++++++
 tb/tb_suprloco_sram_dma.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/suprloco_dma_pkg.sv
// Shared types for the SRAM block-transfer engine: FSM states and mode encodings.
package suprloco_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_CAP    = 3'd2,
        ST_WR     = 3'd3,
        ST_FILLWR = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    function automatic logic is_busy(input state_t s);
        return s inside {ST_RD, ST_CAP, ST_WR, ST_FILLWR};
    endfunction

endpackage

// File: rtl/suprloco_sram_dma.sv
// Ascending block COPY / FILL engine driving one single-port synchronous SRAM.
// Every output is a flop loaded from the values the next state will present.
module suprloco_sram_dma
    import suprloco_dma_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 8,
    parameter int LW = AW + 1
) (
    input  logic          i_MCLK,
    input  logic          i_RST_n,
    input  logic          i_START,
    input  logic          i_MODE,
    input  logic [AW-1:0] i_SRC,
    input  logic [AW-1:0] i_DST,
    input  logic [LW-1:0] i_LEN,
    input  logic [DW-1:0] i_FILLVAL,
    input  logic          i_ABORT,
    output logic          o_BUSY,
    output logic          o_DONE,
    output logic [AW-1:0] o_ADDR,
    output logic [DW-1:0] o_DOUT,
    input  logic [DW-1:0] i_DIN,
    output logic          o_RD,
    output logic          o_WR
);

    localparam logic [LW-1:0] MAX_LEN = LW'(1) << AW;

    state_t        state, state_nxt;
    logic [AW-1:0] src, src_n, dst, dst_n, addr_n;
    logic [LW-1:0] cnt, cnt_n, len_sat;
    logic [DW-1:0] fill, fill_n, dout_n;
    logic          busy_n, done_n, rd_n, wr_n;

    assign len_sat = (i_LEN > MAX_LEN) ? MAX_LEN : i_LEN;

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state  <= ST_IDLE;
            src    <= '0;
            dst    <= '0;
            cnt    <= '0;
            fill   <= '0;
            o_BUSY <= 1'b0;
            o_DONE <= 1'b0;
            o_RD   <= 1'b0;
            o_WR   <= 1'b0;
            o_ADDR <= '0;
            o_DOUT <= '0;
        end else begin
            state  <= state_nxt;
            src    <= src_n;
            dst    <= dst_n;
            cnt    <= cnt_n;
            fill   <= fill_n;
            o_BUSY <= busy_n;
            o_DONE <= done_n;
            o_RD   <= rd_n;
            o_WR   <= wr_n;
            o_ADDR <= addr_n;
            o_DOUT <= dout_n;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:
                if (i_START) begin
                    if (i_LEN == '0)              state_nxt = ST_FIN;
                    else if (i_MODE == MODE_FILL) state_nxt = ST_FILLWR;
                    else                          state_nxt = ST_RD;
                end
            ST_RD:     state_nxt = ST_CAP;
            ST_CAP:    state_nxt = ST_WR;
            ST_WR:     state_nxt = (cnt == LW'(1)) ? ST_FIN : ST_RD;
            ST_FILLWR: state_nxt = (cnt == LW'(1)) ? ST_FIN : ST_FILLWR;
            ST_FIN:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        // Abort wins over everything while a transfer is in flight.
        if (i_ABORT && is_busy(state))
            state_nxt = ST_IDLE;
    end

    always_comb begin
        src_n  = src;
        dst_n  = dst;
        cnt_n  = cnt;
        fill_n = fill;
        addr_n = o_ADDR;
        dout_n = o_DOUT;
        rd_n   = 1'b0;
        wr_n   = 1'b0;
        busy_n = is_busy(state_nxt);
        done_n = (state_nxt == ST_FIN);

        case (state)
            ST_IDLE:
                if (i_START) begin
                    src_n  = i_SRC;
                    dst_n  = i_DST;
                    cnt_n  = len_sat;
                    fill_n = i_FILLVAL;
                end
            ST_WR: begin
                src_n = src + AW'(1);
                dst_n = dst + AW'(1);
                cnt_n = cnt - LW'(1);
            end
            ST_FILLWR: begin
                dst_n = dst + AW'(1);
                cnt_n = cnt - LW'(1);
            end
            default: ;
        endcase

        // WR is only entered from CAP, where the SRAM read data is on i_DIN.
        case (state_nxt)
            ST_RD: begin
                rd_n   = 1'b1;
                addr_n = src_n;
            end
            ST_WR: begin
                wr_n   = 1'b1;
                addr_n = dst_n;
                dout_n = i_DIN;
            end
            ST_FILLWR: begin
                wr_n   = 1'b1;
                addr_n = dst_n;
                dout_n = fill_n;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_suprloco_sram_dma.sv
// Bench for suprloco_sram_dma: behavioural SRAM on the bus, per-cycle expectation queue
// built from the transfer rules, directed cases with literal expectations, then random transfers.
module tb_suprloco_sram_dma;

    localparam int AW = 10, DW = 8, LW = 11, DEPTH = 1 << AW;
    localparam bit COPY = 1'b0, FILL = 1'b1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          i_START = 1'b0, i_MODE = 1'b0, i_ABORT = 1'b0;
    logic [AW-1:0] i_SRC = '0, i_DST = '0;
    logic [LW-1:0] i_LEN = '0;
    logic [DW-1:0] i_FILLVAL = '0;
    logic          o_BUSY, o_DONE, o_RD, o_WR;
    logic [AW-1:0] o_ADDR;
    logic [DW-1:0] o_DOUT;
    logic [DW-1:0] sram_q = '0;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    suprloco_sram_dma #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .i_MCLK(clk), .i_RST_n(rst_n), .i_START(i_START), .i_MODE(i_MODE),
        .i_SRC(i_SRC), .i_DST(i_DST), .i_LEN(i_LEN), .i_FILLVAL(i_FILLVAL),
        .i_ABORT(i_ABORT), .o_BUSY(o_BUSY), .o_DONE(o_DONE), .o_ADDR(o_ADDR),
        .o_DOUT(o_DOUT), .i_DIN(sram_q), .o_RD(o_RD), .o_WR(o_WR)
    );

    // Single-port SRAM: write wins, read data registered.
    logic [DW-1:0] sram [DEPTH];
    always @(posedge clk) begin
        if (o_WR)      sram[o_ADDR] <= o_DOUT;
        else if (o_RD) sram_q <= sram[o_ADDR];
    end

    typedef struct {
        logic          busy, done, rd, wr, cpy;
        logic [AW-1:0] addr, src;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] mmem [DEPTH];
    bit            last_done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit accepting();
        return (q.size() == 0) && !last_done;
    endfunction

    // Expected bus activity, one entry per cycle after the accepting edge.
    task automatic model_start(input bit md, input int s, input int d, input int len, input int fv);
        int   n;
        exp_t e;
        n = (len > DEPTH) ? DEPTH : len;
        for (int i = 0; i < n; i++) begin
            if (md == COPY) begin
                e = '{default: 0}; e.busy = 1; e.rd = 1; e.addr = AW'(s + i); q.push_back(e);
                e = '{default: 0}; e.busy = 1; q.push_back(e);
                e = '{default: 0}; e.busy = 1; e.wr = 1; e.cpy = 1;
                e.addr = AW'(d + i); e.src = AW'(s + i); q.push_back(e);
            end else begin
                e = '{default: 0}; e.busy = 1; e.wr = 1; e.addr = AW'(d + i); e.dat = DW'(fv);
                q.push_back(e);
            end
        end
        e = '{default: 0}; e.done = 1; q.push_back(e);
    endtask

    // Compare process: every cycle, #1 after the edge.
    exp_t          ce;
    logic          pend_v = 0;
    logic [AW-1:0] pend_a;
    logic [DW-1:0] pend_d, wd;
    initial begin
        forever begin
            @(posedge clk);
            if (pend_v && rst_n) mmem[pend_a] = pend_d;
            pend_v = 0;
            #1;
            if (q.size() != 0) begin ce = q.pop_front(); last_done = ce.done; end
            else begin ce = '{default: 0}; last_done = 0; end
            chk("ctl{busy,done,rd,wr}", {o_BUSY, o_DONE, o_RD, o_WR}, {ce.busy, ce.done, ce.rd, ce.wr});
            if (ce.rd) chk("rd_addr", o_ADDR, ce.addr);
            if (ce.wr) begin
                wd = ce.cpy ? mmem[ce.src] : ce.dat;
                chk("wr_addr", o_ADDR, ce.addr);
                chk("wr_data", o_DOUT, wd);
                pend_v = 1; pend_a = ce.addr; pend_d = wd;
            end
        end
    end

    // abort_at: -1 none, 0 together with start, k>0 in cycle k after start.
    task automatic run_xfer(input bit md, input int s, input int d, input int len, input int fv,
                            input int abort_at, input bit extra,
                            output int done_cyc, output int wr_cyc, output int busy_cyc);
        int n;
        @(negedge clk);
        i_MODE = md; i_SRC = AW'(s); i_DST = AW'(d); i_LEN = LW'(len); i_FILLVAL = DW'(fv);
        i_START = 1; i_ABORT = (abort_at == 0);
        if (accepting()) model_start(md, s, d, len, fv);
        n = 0; done_cyc = -1; wr_cyc = 0; busy_cyc = 0;
        while (1) begin
            @(negedge clk);
            n++;
            i_START = 0; i_ABORT = 0;
            if (o_WR) wr_cyc++;
            if (o_BUSY) busy_cyc++;
            if (o_DONE && done_cyc < 0) done_cyc = n;
            if (abort_at > 0 && n == abort_at) begin
                i_ABORT = 1;
                if (q.size() != 0) q.delete();
            end
            if (extra && n == 3) begin
                i_LEN = LW'(2); i_DST = AW'(12'h050); i_FILLVAL = 8'h99; i_START = 1;
                if (accepting()) model_start(FILL, 0, 'h50, 2, 'h99);
            end
            if (!i_ABORT && !i_START && accepting()) break;
            if (n > 4000) begin
                chk("xfer_timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic preset(input int a, input int v);
        sram[a] = DW'(v); mmem[a] = DW'(v);
    endtask

    int dc, wc, bc, bad, ln, ab, s, d;
    bit md;

    initial begin
        for (int i = 0; i < DEPTH; i++) preset(i, $urandom_range(255));
        #1 rst_n = 0;
        #1;
        chk("reset_ctl", {o_BUSY, o_DONE, o_RD, o_WR}, 0);
        chk("reset_addr", o_ADDR, 0);
        chk("reset_dout", o_DOUT, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // 1: FILL 4 words of A5 at 0x010
        run_xfer(FILL, 0, 'h010, 4, 'hA5, -1, 0, dc, wc, bc);
        chk("t1_done_cycle", dc, 5);
        chk("t1_wr_cycles", wc, 4);
        for (int i = 0; i < 4; i++) chk("t1_ram", sram['h10 + i], 8'hA5);

        // 2: COPY 11,22,33 from 0x000 to 0x100
        preset(0, 'h11); preset(1, 'h22); preset(2, 'h33);
        run_xfer(COPY, 0, 'h100, 3, 0, -1, 0, dc, wc, bc);
        chk("t2_done_cycle", dc, 10);
        chk("t2_ram0", sram['h100], 8'h11);
        chk("t2_ram1", sram['h101], 8'h22);
        chk("t2_ram2", sram['h102], 8'h33);

        // 3: FILL wrapping past the top of memory
        run_xfer(FILL, 0, 'h3FE, 3, 'h5A, -1, 0, dc, wc, bc);
        chk("t3_ram3fe", sram['h3FE], 8'h5A);
        chk("t3_ram3ff", sram['h3FF], 8'h5A);
        chk("t3_ram000", sram['h000], 8'h5A);
        chk("t3_ram001", sram['h001], 8'h22);

        // 4: zero length
        run_xfer(COPY, 'h40, 'h80, 0, 0, -1, 0, dc, wc, bc);
        chk("t4_done_cycle", dc, 1);
        chk("t4_wr_cycles", wc, 0);
        chk("t4_busy_cycles", bc, 0);

        // 5: abort in cycle 7 of an 8-word COPY
        for (int i = 0; i < 8; i++) begin preset('h200 + i, 'h40 + i); preset('h280 + i, 'hEE); end
        run_xfer(COPY, 'h200, 'h280, 8, 0, 7, 0, dc, wc, bc);
        chk("t5_no_done", dc, -1);
        chk("t5_wr_cycles", wc, 2);
        chk("t5_ram0", sram['h280], 8'h40);
        chk("t5_ram1", sram['h281], 8'h41);
        chk("t5_ram2", sram['h282], 8'hEE);

        // start together with abort in IDLE is accepted
        run_xfer(FILL, 0, 'h020, 2, 'h3C, 0, 0, dc, wc, bc);
        chk("abort_start_done_cycle", dc, 3);

        // 6a: second start while busy is ignored
        preset('h50, 'h12);
        run_xfer(FILL, 0, 'h040, 6, 'h66, -1, 1, dc, wc, bc);
        chk("t6_done_cycle", dc, 7);
        chk("t6_wr_cycles", wc, 6);
        chk("t6_ignored_ram", sram['h50], 8'h12);

        // 6b: asynchronous reset in the middle of a FILL
        @(negedge clk);
        i_MODE = FILL; i_DST = AW'(12'h300); i_LEN = LW'(20); i_FILLVAL = 8'h77; i_START = 1;
        model_start(FILL, 0, 'h300, 20, 'h77);
        @(negedge clk); i_START = 0;
        repeat (5) @(negedge clk);
        #2 rst_n = 0;
        q.delete(); last_done = 0;
        #1;
        chk("t6_async_ctl", {o_BUSY, o_DONE, o_RD, o_WR}, 0);
        chk("t6_async_addr", o_ADDR, 0);
        chk("t6_async_dout", o_DOUT, 0);
        @(negedge clk); rst_n = 1;
        chk("t6_partial_ram", sram['h304], 8'h77);

        // random transfers, some overlapping, some aborted, one oversize length
        for (int it = 0; it < 40; it++) begin
            md = $urandom_range(1);
            s  = $urandom_range(DEPTH - 1);
            d  = ($urandom_range(3) == 0) ? s + $urandom_range(1, 4) : $urandom_range(DEPTH - 1);
            ln = $urandom_range(0, 24);
            if (it == 5) begin md = FILL; ln = 1500; end
            ab = ($urandom_range(3) == 0) ? $urandom_range(1, (md == COPY) ? 3 * ln + 1 : ln + 1) : -1;
            run_xfer(md, s, d, ln, $urandom_range(255), ab, 0, dc, wc, bc);
            if (it == 5 && ab < 0) chk("sat_wr_cycles", wc, DEPTH);
        end

        repeat (3) @(negedge clk);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (sram[i] !== mmem[i]) bad++;
        chk("mem_final_bad_words", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
